// File: rtl/ip_hdr_check_ttl_param.sv
// IPv4 header checker: ones-complement header sum, TTL decrement with
// incremental checksum update, header sanity flags, and a fall-through
// result FIFO read by the forwarding processor.
//
// state | meaning
// IDLE  | between packets, waiting for in_sop
// HDR   | accumulating header lanes
// DONE  | header finished (or truncated); fold pipeline launched
// SKIP  | discarding payload until in_eop
module ip_hdr_check_ttl_param #(
    parameter int DATA_WIDTH        = 64,
    parameter int IP_OFFSET_BYTES   = 14,
    parameter int RESULT_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_wr,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  result_vld,
    input  logic                  rd_result,
    output logic                  result_chk_good,
    output logic [15:0]           result_new_chk,
    output logic                  result_ttl_good,
    output logic [7:0]            result_new_ttl,
    output logic                  result_has_options,
    output logic                  result_hdr_err,
    output logic                  result_drop
);

    localparam int         LANES = DATA_WIDTH / 16;
    localparam int         DEPTH = 1 << RESULT_DEPTH_BITS;
    localparam int         REC_W = 28;
    localparam logic [9:0] OFF   = 10'(IP_OFFSET_BYTES);
    localparam logic [9:0] BPW   = 10'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, HDR, DONE, SKIP} state_t;

    state_t      state, state_nx;
    logic [9:0]  byte_cnt;
    logic [23:0] acc;
    logic [3:0]  ihl_r;
    logic        bad_r, trunc_r, done_eop, fold_go;
    logic [7:0]  ttl_r;
    logic [15:0] hc_r;

    logic [9:0]  base, hdr_end, p;
    logic [15:0] lane;
    logic [3:0]  ihl_nx, ihl_eff;
    logic        bad_nx;
    logic [7:0]  ttl_nx;
    logic [15:0] hc_nx;
    logic [23:0] word_sum;
    logic        hdr_word, complete, launch;

    // Decode the current word: capture header fields and sum in-header lanes.
    always_comb begin
        base     = in_sop ? 10'd0 : byte_cnt;
        hdr_word = in_wr & (in_sop | (state == HDR));
        ihl_nx   = in_sop ? 4'd5  : ihl_r;
        bad_nx   = in_sop ? 1'b0  : bad_r;
        ttl_nx   = in_sop ? 8'd0  : ttl_r;
        hc_nx    = in_sop ? 16'd0 : hc_r;
        word_sum = 24'd0;
        p        = 10'd0;
        lane     = 16'd0;
        for (int j = 0; j < LANES; j++) begin
            p    = base + 10'(2 * j);
            lane = in_data[DATA_WIDTH-1-16*j -: 16];
            if (p == OFF) begin
                ihl_nx = lane[11:8];
                bad_nx = (lane[15:12] != 4'd4) || (lane[11:8] < 4'd5);
            end
            if (p == OFF + 10'd8)  ttl_nx = lane[15:8];
            if (p == OFF + 10'd10) hc_nx  = lane;
        end
        // A short IHL is flagged as an error; the minimal header length is
        // still used so the fields and the checksum lanes are well defined.
        ihl_eff = (ihl_nx < 4'd5) ? 4'd5 : ihl_nx;
        hdr_end = OFF + {4'b0, ihl_eff, 2'b00};
        for (int j = 0; j < LANES; j++) begin
            p    = base + 10'(2 * j);
            lane = in_data[DATA_WIDTH-1-16*j -: 16];
            if ((p >= OFF) && (p + 10'd2 <= hdr_end))
                word_sum = word_sum + {8'b0, lane};
        end
        complete = (hdr_end <= base + BPW);
        launch   = hdr_word & (complete | in_eop);
    end

    // Byte counter, accumulator and captured header fields.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            byte_cnt <= 10'd0;
            acc      <= 24'd0;
            ihl_r    <= 4'd5;
            bad_r    <= 1'b0;
            ttl_r    <= 8'd0;
            hc_r     <= 16'd0;
            trunc_r  <= 1'b0;
            done_eop <= 1'b0;
            fold_go  <= 1'b0;
        end else begin
            fold_go <= launch;
            if (in_wr)
                byte_cnt <= (base > 10'd768) ? base : base + BPW;
            if (hdr_word) begin
                acc   <= (in_sop ? 24'd0 : acc) + word_sum;
                ihl_r <= ihl_nx;
                bad_r <= bad_nx;
                ttl_r <= ttl_nx;
                hc_r  <= hc_nx;
            end
            if (launch) begin
                trunc_r  <= ~complete;
                done_eop <= in_eop;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM next state; idle cycles (in_wr=0) hold the state.
    always_comb begin
        state_nx = state;
        if (in_wr) begin
            if (in_sop || (state == HDR)) begin
                state_nx = (complete || in_eop) ? DONE : HDR;
            end else begin
                case (state)
                    DONE:    state_nx = (done_eop || in_eop) ? IDLE : SKIP;
                    SKIP:    state_nx = in_eop ? IDLE : SKIP;
                    default: state_nx = state;
                endcase
            end
        end
    end

    logic        p1_vld, p2_vld, p1_opt, p2_opt, p1_err, p2_err;
    logic [16:0] p1_s;
    logic [15:0] p2_f, p1_hc, p2_hc;
    logic [7:0]  p1_ttl, p2_ttl;

    // Two-stage fold; snapshots the packet fields so the next header can
    // start accumulating while this one is still folding.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p1_vld <= 1'b0; p1_s <= 17'd0; p1_hc <= 16'd0; p1_ttl <= 8'd0;
            p1_opt <= 1'b0; p1_err <= 1'b0;
            p2_vld <= 1'b0; p2_f <= 16'd0; p2_hc <= 16'd0; p2_ttl <= 8'd0;
            p2_opt <= 1'b0; p2_err <= 1'b0;
        end else begin
            p1_vld <= fold_go;
            if (fold_go) begin
                p1_s   <= {1'b0, acc[15:0]} + {9'b0, acc[23:16]};
                p1_hc  <= hc_r;
                p1_ttl <= ttl_r;
                p1_opt <= (ihl_r != 4'd5);
                p1_err <= bad_r | trunc_r;
            end
            p2_vld <= p1_vld;
            if (p1_vld) begin
                p2_f   <= p1_s[15:0] + {15'b0, p1_s[16]};
                p2_hc  <= p1_hc;
                p2_ttl <= p1_ttl;
                p2_opt <= p1_opt;
                p2_err <= p1_err;
            end
        end
    end

    logic [16:0]      t_chk;
    logic [15:0]      new_chk;
    logic [REC_W-1:0] rec;

    // Result record: RFC 1141 checksum update and TTL decrement.
    always_comb begin
        t_chk   = {1'b0, p2_hc} + 17'h00100;
        new_chk = (p2_ttl == 8'd0) ? p2_hc : (t_chk[15:0] + {15'b0, t_chk[16]});
        rec     = {(p2_f == 16'hFFFF) & ~p2_err,
                   new_chk,
                   (p2_ttl > 8'd1),
                   (p2_ttl == 8'd0) ? 8'd0 : p2_ttl - 8'd1,
                   p2_opt,
                   p2_err};
    end

    logic [REC_W-1:0]             mem [DEPTH];
    logic [RESULT_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [RESULT_DEPTH_BITS:0]   count;
    logic                         full, do_wr, do_rd;

    assign full  = (count == (RESULT_DEPTH_BITS+1)'(DEPTH));
    assign do_wr = p2_vld & ~full & resetn;
    assign do_rd = rd_result & (count != '0);

    // FIFO pointers, occupancy and drop pulse; a pop never frees a slot
    // for a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            result_drop <= 1'b0;
        end else begin
            result_drop <= p2_vld & full;
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= rec;
    end

    assign result_vld = (count != '0);
    assign {result_chk_good, result_new_chk, result_ttl_good, result_new_ttl,
            result_has_options, result_hdr_err} = mem[rd_ptr] & {REC_W{result_vld}};

endmodule

// File: tb/tb_ip_hdr_check_ttl_param.sv
// Directed bench: a 64-bit instance for the IHL=5 table, timing, truncation,
// FIFO and reset sequences, and a 128-bit instance for option headers.
module tb_ip_hdr_check_ttl_param;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [63:0]  a_data;
    logic         a_wr, a_sop, a_eop, a_rd;
    logic         a_vld, a_good, a_tg, a_opt, a_err, a_drop;
    logic [15:0]  a_nchk;
    logic [7:0]   a_nttl;
    logic [127:0] b_data;
    logic         b_wr, b_sop, b_eop, b_rd;
    logic         b_vld, b_good, b_tg, b_opt, b_err, b_drop;
    logic [15:0]  b_nchk;
    logic [7:0]   b_nttl;

    ip_hdr_check_ttl_param #(.DATA_WIDTH(64), .IP_OFFSET_BYTES(14), .RESULT_DEPTH_BITS(2)) dut64 (
        .clk(clk), .resetn(resetn), .in_data(a_data), .in_wr(a_wr), .in_sop(a_sop),
        .in_eop(a_eop), .result_vld(a_vld), .rd_result(a_rd), .result_chk_good(a_good),
        .result_new_chk(a_nchk), .result_ttl_good(a_tg), .result_new_ttl(a_nttl),
        .result_has_options(a_opt), .result_hdr_err(a_err), .result_drop(a_drop));

    ip_hdr_check_ttl_param #(.DATA_WIDTH(128), .IP_OFFSET_BYTES(14), .RESULT_DEPTH_BITS(2)) dut128 (
        .clk(clk), .resetn(resetn), .in_data(b_data), .in_wr(b_wr), .in_sop(b_sop),
        .in_eop(b_eop), .result_vld(b_vld), .rd_result(b_rd), .result_chk_good(b_good),
        .result_new_chk(b_nchk), .result_ttl_good(b_tg), .result_new_ttl(b_nttl),
        .result_has_options(b_opt), .result_hdr_err(b_err), .result_drop(b_drop));

    typedef struct {
        logic [7:0]  ttl;
        logic [15:0] hc;
        logic        good;
        logic [15:0] nchk;
        logic        tg;
        logic [7:0]  nttl;
    } vec_t;

    typedef struct {
        logic        good;
        logic [15:0] nchk;
        logic        tg;
        logic [7:0]  nttl;
        logic        opt;
        logic        err;
    } rec_t;

    int         checks = 0;
    int         errors = 0;
    int         a_drops = 0;
    logic [7:0] pkt [256];
    vec_t       vt [7];

    always @(negedge clk) if (a_drop === 1'b1) a_drops++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input int ihl, input logic [7:0] ttl, input bit auto_chk,
                         input logic [15:0] hc, input int len);
        logic [31:0] s;
        logic [15:0] c;
        for (int i = 0; i < 256; i++) pkt[i] = (i < 14) ? 8'hAA : ((i < len) ? 8'h5A : 8'h00);
        pkt[14] = {4'h4, 4'(ihl)}; pkt[15] = 8'h00; pkt[16] = 8'h00; pkt[17] = 8'h73;
        pkt[18] = 8'h00; pkt[19] = 8'h00; pkt[20] = 8'h40; pkt[21] = 8'h00;
        pkt[22] = ttl;   pkt[23] = 8'h11; pkt[24] = hc[15:8]; pkt[25] = hc[7:0];
        pkt[26] = 8'hC0; pkt[27] = 8'hA8; pkt[28] = 8'h00; pkt[29] = 8'h01;
        pkt[30] = 8'hC0; pkt[31] = 8'hA8; pkt[32] = 8'h00; pkt[33] = 8'hC7;
        for (int i = 20; i < 4 * ihl; i++) pkt[14+i] = 8'(i * 7 + 3);
        if (auto_chk) begin
            pkt[24] = 8'h00; pkt[25] = 8'h00;
            s = 32'd0;
            for (int i = 0; i < 2 * ihl; i++) s = s + {16'd0, pkt[14+2*i], pkt[15+2*i]};
            s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
            s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
            c = ~s[15:0];
            pkt[24] = c[15:8]; pkt[25] = c[7:0];
        end
    endtask

    task automatic send(input bit wide, input int len, input bit do_sop, input bit do_eop);
        int bpw;
        int nw;
        bpw = wide ? 16 : 8;
        nw  = (len + bpw - 1) / bpw;
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            if (wide) begin
                b_wr = 1'b1; b_sop = do_sop && (w == 0); b_eop = do_eop && (w == nw - 1);
                for (int b = 0; b < 16; b++) b_data[127-8*b -: 8] = pkt[16*w+b];
            end else begin
                a_wr = 1'b1; a_sop = do_sop && (w == 0); a_eop = do_eop && (w == nw - 1);
                for (int b = 0; b < 8; b++) a_data[63-8*b -: 8] = pkt[8*w+b];
            end
        end
        @(negedge clk);
        a_wr = 1'b0; a_sop = 1'b0; a_eop = 1'b0;
        b_wr = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
    endtask

    task automatic pop(input bit wide, input string name, output rec_t r);
        bit got;
        got = 1'b0;
        r   = '{1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((wide ? b_vld : a_vld) === 1'b1) got = 1'b1;
        end
        chk({name, "_present"}, {31'd0, got}, 32'd1);
        if (got) begin
            if (wide) r = '{b_good, b_nchk, b_tg, b_nttl, b_opt, b_err};
            else      r = '{a_good, a_nchk, a_tg, a_nttl, a_opt, a_err};
            if (wide) b_rd = 1'b1; else a_rd = 1'b1;
            @(negedge clk);
            a_rd = 1'b0; b_rd = 1'b0;
        end
    endtask

    task automatic expect_empty(input bit wide, input string name);
        repeat (8) @(negedge clk);
        chk({name, "_empty"}, {31'd0, wide ? b_vld : a_vld}, 32'd0);
    endtask

    rec_t r;

    initial begin
        resetn = 1'b0;
        a_data = '0; a_wr = 0; a_sop = 0; a_eop = 0; a_rd = 0;
        b_data = '0; b_wr = 0; b_sop = 0; b_eop = 0; b_rd = 0;
        vt[0] = '{8'h40, 16'hB861, 1'b1, 16'hB961, 1'b1, 8'h3F};
        vt[1] = '{8'h40, 16'hB862, 1'b0, 16'hB962, 1'b1, 8'h3F};
        vt[2] = '{8'h01, 16'hF761, 1'b1, 16'hF861, 1'b0, 8'h00};
        vt[3] = '{8'h00, 16'hF861, 1'b1, 16'hF861, 1'b0, 8'h00};
        vt[4] = '{8'h40, 16'hFF00, 1'b0, 16'h0001, 1'b1, 8'h3F};
        vt[5] = '{8'h02, 16'hF661, 1'b1, 16'hF761, 1'b1, 8'h01};
        vt[6] = '{8'hFF, 16'hF960, 1'b1, 16'hFA60, 1'b1, 8'hFE};

        repeat (3) @(negedge clk);
        chk("rst_vld64", {31'd0, a_vld}, 32'd0);
        chk("rst_vld128", {31'd0, b_vld}, 32'd0);
        chk("rst_drop64", {31'd0, a_drop}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // IHL=5 table on the 64-bit instance
        for (int i = 0; i < 7; i++) begin
            build(5, vt[i].ttl, 1'b0, vt[i].hc, 48);
            send(1'b0, 48, 1'b1, 1'b1);
            pop(1'b0, $sformatf("vec%0d", i), r);
            chk($sformatf("vec%0d_chk_good", i), {31'd0, r.good}, {31'd0, vt[i].good});
            chk($sformatf("vec%0d_new_chk", i), {16'd0, r.nchk}, {16'd0, vt[i].nchk});
            chk($sformatf("vec%0d_ttl_good", i), {31'd0, r.tg}, {31'd0, vt[i].tg});
            chk($sformatf("vec%0d_new_ttl", i), {24'd0, r.nttl}, {24'd0, vt[i].nttl});
            chk($sformatf("vec%0d_opt", i), {31'd0, r.opt}, 32'd0);
            chk($sformatf("vec%0d_err", i), {31'd0, r.err}, 32'd0);
        end
        expect_empty(1'b0, "table");

        // result_vld latency: header ends in word 4, visible 4 cycles later
        build(5, 8'h40, 1'b0, 16'hB861, 40);
        send(1'b0, 40, 1'b1, 1'b1);
        chk("lat_n1", {31'd0, a_vld}, 32'd0);
        @(negedge clk); chk("lat_n2", {31'd0, a_vld}, 32'd0);
        @(negedge clk); chk("lat_n3", {31'd0, a_vld}, 32'd0);
        @(negedge clk); chk("lat_n4", {31'd0, a_vld}, 32'd1);
        pop(1'b0, "lat", r);
        chk("lat_chk_good", {31'd0, r.good}, 32'd1);

        // truncated header: eop on the word holding byte 30
        build(5, 8'h40, 1'b0, 16'hB861, 32);
        send(1'b0, 32, 1'b1, 1'b1);
        pop(1'b0, "trunc", r);
        chk("trunc_err", {31'd0, r.err}, 32'd1);
        chk("trunc_chk_good", {31'd0, r.good}, 32'd0);
        expect_empty(1'b0, "trunc");

        // bad version nibble
        build(5, 8'h40, 1'b0, 16'hB861, 48);
        pkt[14] = 8'h65;
        send(1'b0, 48, 1'b1, 1'b1);
        pop(1'b0, "badver", r);
        chk("badver_err", {31'd0, r.err}, 32'd1);
        chk("badver_chk_good", {31'd0, r.good}, 32'd0);

        // sop mid-header: the aborted packet leaves no record
        build(5, 8'h20, 1'b0, 16'h0000, 48);
        send(1'b0, 16, 1'b1, 1'b0);
        build(5, 8'h40, 1'b0, 16'hB861, 48);
        send(1'b0, 48, 1'b1, 1'b1);
        pop(1'b0, "restart", r);
        chk("restart_chk_good", {31'd0, r.good}, 32'd1);
        chk("restart_new_ttl", {24'd0, r.nttl}, 32'h3F);
        expect_empty(1'b0, "restart");

        // FIFO overflow: five packets, no reads
        begin
            int d0;
            d0 = a_drops;
            for (int k = 0; k < 5; k++) begin
                build(5, 8'(16 * (k + 1)), 1'b0, 16'h1234, 40);
                send(1'b0, 40, 1'b1, 1'b1);
            end
            repeat (8) @(negedge clk);
            chk("ovf_drops", 32'(a_drops - d0), 32'd1);
            for (int k = 0; k < 4; k++) begin
                pop(1'b0, $sformatf("ovf%0d", k), r);
                chk($sformatf("ovf%0d_new_ttl", k), {24'd0, r.nttl}, 32'(16 * (k + 1) - 1));
            end
            expect_empty(1'b0, "ovf");
        end

        // 128-bit instance: IHL 5, 6 and 15 with valid checksums
        build(5, 8'h40, 1'b0, 16'hB861, 48);
        send(1'b1, 48, 1'b1, 1'b1);
        pop(1'b1, "w5", r);
        chk("w5_chk_good", {31'd0, r.good}, 32'd1);
        chk("w5_new_chk", {16'd0, r.nchk}, 32'hB961);
        chk("w5_opt", {31'd0, r.opt}, 32'd0);
        build(6, 8'h40, 1'b1, 16'h0000, 64);
        send(1'b1, 64, 1'b1, 1'b1);
        pop(1'b1, "w6", r);
        chk("w6_chk_good", {31'd0, r.good}, 32'd1);
        chk("w6_opt", {31'd0, r.opt}, 32'd1);
        chk("w6_err", {31'd0, r.err}, 32'd0);
        build(15, 8'h40, 1'b1, 16'h0000, 96);
        send(1'b1, 96, 1'b1, 1'b1);
        pop(1'b1, "w15", r);
        chk("w15_chk_good", {31'd0, r.good}, 32'd1);
        chk("w15_opt", {31'd0, r.opt}, 32'd1);
        chk("w15_new_ttl", {24'd0, r.nttl}, 32'h3F);
        expect_empty(1'b1, "w15");

        // reset mid-header with a record queued
        build(5, 8'h40, 1'b0, 16'hB861, 48);
        send(1'b0, 48, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        chk("prerst_vld", {31'd0, a_vld}, 32'd1);
        send(1'b0, 16, 1'b1, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst2_vld", {31'd0, a_vld}, 32'd0);
        chk("rst2_outs", {a_good, a_nchk, a_tg, a_nttl, a_opt, a_err, a_drop}, 32'd0);
        send(1'b0, 48, 1'b0, 1'b1);
        expect_empty(1'b0, "nosop");
        send(1'b0, 48, 1'b1, 1'b1);
        pop(1'b0, "postrst", r);
        chk("postrst_chk_good", {31'd0, r.good}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
